// File: rtl/ram_bus_pkg.sv
// Shared types and timing defaults for the RAM bus master.
package ram_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  localparam int DEF_ADDR_WIDTH    = 16;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;

  // Phase counter width able to hold the longest phase length.
  function automatic int cnt_width(input int s, input int t, input int h);
    int m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ram_bus_if.sv
// CPU-side request/response handshake of the RAM bus master.
interface ram_bus_if
  import ram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_bus_phase_counter.sv
// Loadable down-counter; done flags the last cycle of the current phase.
module ram_bus_phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Turns single-word valid/ready requests into one setup/strobe/hold cycle
// on the asynchronous RAM bus and returns a one-cycle response.
//
// state  | meaning
// IDLE   | ready for a request, bus released
// SETUP  | addr/write/data stable, enable low
// STROBE | enable high; read data sampled on the last cycle
// HOLD   | enable low, addr/write/data still held
// RESP   | rsp_valid pulse, bus released
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_bus_if.master             req_if,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_enable,
  output logic                  bus_write
);

  localparam int CW = cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  // Counter is loaded with N-1 so done is the terminal-count (zero) compare.
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);

  state_t                state, state_next;
  logic                  cnt_load;
  logic [CW-1:0]         cnt_val;
  logic                  cnt_done;
  logic                  accept;
  logic                  in_cycle_next;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  assign accept        = (state == IDLE) && req_if.req_valid;
  assign in_cycle_next = (state_next == SETUP) || (state_next == STROBE) ||
                         (state_next == HOLD);

  ram_bus_phase_counter #(.WIDTH(CW)) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    case (state)
      IDLE: if (req_if.req_valid) begin
        state_next = SETUP;
        cnt_load   = 1'b1;
        cnt_val    = SETUP_LOAD;
      end
      SETUP: if (cnt_done) begin
        state_next = STROBE;
        cnt_load   = 1'b1;
        cnt_val    = STROBE_LOAD;
      end
      STROBE: if (cnt_done) begin
        state_next = HOLD;
        cnt_load   = 1'b1;
        cnt_val    = HOLD_LOAD;
      end
      HOLD:    if (cnt_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered from state_next so the strobe cannot glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_addr    <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      bus_enable  <= 1'b0;
      bus_write   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        bus_addr <= req_if.req_addr;
        write_q  <= req_if.req_write;
        wdata_q  <= req_if.req_wdata;
      end
      bus_enable  <= (state_next == STROBE);
      bus_write   <= in_cycle_next && (accept ? req_if.req_write : write_q);
      rsp_valid_q <= (state_next == RESP);
      if ((state == STROBE) && cnt_done) begin
        rsp_rdata_q <= write_q ? '0 : bus_data;
      end
    end
  end

  assign bus_data         = bus_write ? wdata_q : {DATA_WIDTH{1'bz}};
  assign req_if.req_ready = (state == IDLE);
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;

endmodule
